// File: rtl/bcd_binary_decoder_if.sv
// Handshake bundle for the packed-BCD to binary decoder: operand in, result out.
interface bcd_binary_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_bcd;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_bin;
  logic       out_err;

  modport master (
    output in_valid,
    output in_bcd,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bin,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_bcd,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bin,
    output out_err
  );
endinterface

// File: rtl/bcd_binary_decoder.sv
// Two-digit packed BCD to 7-bit binary converter using eight reverse double-dabble steps.
// Fixed latency regardless of operand validity; one operand in flight at a time.
module bcd_binary_decoder (
  input logic                  clk,
  input logic                  rst,
  bcd_binary_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [3:0]  tens_q;
  logic [3:0]  ones_q;
  logic [7:0]  bin_q;
  logic        err_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [6:0]  out_bin_q;
  logic        out_err_q;

  logic [15:0] shifted;
  logic [3:0]  tens_step;
  logic [3:0]  ones_step;
  logic [7:0]  bin_step;

  // One reverse double-dabble step: shift right, then pull back any nibble that reached 8+.
  always_comb begin
    shifted   = {tens_q, ones_q, bin_q} >> 1;
    tens_step = (shifted[15:12] >= 4'd8) ? shifted[15:12] - 4'd3 : shifted[15:12];
    ones_step = (shifted[11:8] >= 4'd8) ? shifted[11:8] - 4'd3 : shifted[11:8];
    bin_step  = shifted[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      bin_q       <= 8'd0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bin_q   <= 7'd0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            tens_q     <= bus.in_bcd[7:4];
            ones_q     <= bus.in_bcd[3:0];
            bin_q      <= 8'd0;
            err_q      <= (bus.in_bcd[7:4] > 4'd9) || (bus.in_bcd[3:0] > 4'd9);
            cnt_q      <= 3'd0;
            in_ready_q <= 1'b0;
            state_q    <= StConv;
          end
        end
        StConv: begin
          tens_q <= tens_step;
          ones_q <= ones_step;
          bin_q  <= bin_step;
          cnt_q  <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            // Invalid operands still run the full datapath; the result is simply masked.
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            out_bin_q   <= err_q ? 7'd0 : bin_step[6:0];
            out_err_q   <= err_q;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_bin_q   <= 7'd0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          cnt_q       <= 3'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_bin_q   <= 7'd0;
          out_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_binary_decoder.sv
// Directed and exhaustive checks of the BCD decoder: latency, error flag, backpressure, reset.
module tb_bcd_binary_decoder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  bcd_binary_decoder_if bus ();

  bcd_binary_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one operand, count edges from accept to out_valid, capture result, then release it.
  task automatic run_op(input logic [7:0] bcd, output logic [6:0] b, output logic e,
                        output int lat, output logic rdy_before, output logic rdy_after);
    @(negedge clk);
    rdy_before   = bus.in_ready;
    bus.in_valid = 1'b1;
    bus.in_bcd   = bcd;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_bcd   = 8'hEE;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    b = bus.out_bin;
    e = bus.out_err;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    rdy_after = bus.in_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_bin, bus.out_err} !== {1'b1, 1'b0, 7'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b bin=%0d err=%b, want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_bin, bus.out_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_valid();
    logic [7:0] vin [5] = '{8'h99, 8'h00, 8'h42, 8'h09, 8'h90};
    logic [6:0] vexp [5] = '{7'h63, 7'h00, 7'h2A, 7'h09, 7'h5A};
    logic [6:0] b;
    logic e, rb, ra;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(vin[i], b, e, lat, rb, ra);
      n_cmp++;
      if (b !== vexp[i] || e !== 1'b0) begin
        n_bad++;
        $display("FAIL valid_%h: got bin=%h err=%b, want bin=%h err=0", vin[i], b, e, vexp[i]);
      end
      n_cmp++;
      if (lat !== 8) begin
        n_bad++;
        $display("FAIL latency_%h: got %0d, want 8", vin[i], lat);
      end
      n_cmp++;
      if (rb !== 1'b1 || ra !== 1'b1) begin
        n_bad++;
        $display("FAIL ready_%h: got before=%b after=%b, want 1 1", vin[i], rb, ra);
      end
    end
  endtask

  task automatic test_invalid();
    logic [7:0] vin [3] = '{8'h1A, 8'hA1, 8'hFF};
    logic [6:0] b;
    logic e, rb, ra;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(vin[i], b, e, lat, rb, ra);
      n_cmp++;
      if (b !== 7'd0 || e !== 1'b1) begin
        n_bad++;
        $display("FAIL invalid_%h: got bin=%h err=%b, want bin=00 err=1", vin[i], b, e);
      end
      n_cmp++;
      if (lat !== 8) begin
        n_bad++;
        $display("FAIL inv_latency_%h: got %0d, want 8", vin[i], lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad_cycles;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bcd   = 8'h42;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    bad_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.in_valid = c[0];
      if ({bus.out_valid, bus.in_ready, bus.out_bin, bus.out_err} !== {1'b1, 1'b0, 7'h2A, 1'b0})
        bad_cycles++;
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++;
      $display("FAIL backpressure_hold: got %0d unstable cycles, want 0", bad_cycles);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.out_bin} !== {1'b0, 1'b1, 7'd0}) begin
      n_bad++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b bin=%h, want 0 1 00",
               bus.out_valid, bus.in_ready, bus.out_bin);
    end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    int res_cyc [2];
    logic [6:0] res [2];
    int n_acc, n_res;
    n_acc = 0;
    n_res = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && n_res < 2) begin
        res[n_res]     = bus.out_bin;
        res_cyc[n_res] = cyc;
        n_res++;
      end
      bus.in_valid = (n_acc < 2);
      bus.in_bcd   = (n_acc == 0) ? 8'h12 : 8'h34;
      if (bus.in_ready && n_acc < 2) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++;
    if (n_acc !== 2 || n_res !== 2) begin
      n_bad++;
      $display("FAIL b2b_count: got accepts=%0d results=%0d, want 2 2", n_acc, n_res);
    end else begin
      n_cmp++;
      if (acc[1] - acc[0] !== 10) begin
        n_bad++;
        $display("FAIL b2b_spacing: got %0d, want 10", acc[1] - acc[0]);
      end
      n_cmp++;
      if (res[0] !== 7'h0C || res[1] !== 7'h22) begin
        n_bad++;
        $display("FAIL b2b_results: got %h %h, want 0c 22", res[0], res[1]);
      end
      n_cmp++;
      if (res_cyc[0] - acc[0] !== 9 || res_cyc[1] - acc[1] !== 9) begin
        n_bad++;
        $display("FAIL b2b_latency: got %0d %0d, want 9 9",
                 res_cyc[0] - acc[0], res_cyc[1] - acc[1]);
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    int seen;
    logic [6:0] b;
    logic e, rb, ra;
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bcd   = 8'h55;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_bin, bus.out_err} !== {1'b1, 1'b0, 7'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_async: got rdy=%b vld=%b bin=%h err=%b, want 1 0 00 0",
               bus.in_ready, bus.out_valid, bus.out_bin, bus.out_err);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    bus.out_ready = 1'b0;
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL reset_abandon: got %0d result cycles, want 0", seen);
    end
    run_op(8'h07, b, e, lat, rb, ra);
    n_cmp++;
    if (b !== 7'h07 || e !== 1'b0 || lat !== 8) begin
      n_bad++;
      $display("FAIL after_reset_07: got bin=%h err=%b lat=%0d, want 07 0 8", b, e, lat);
    end
  endtask

  task automatic test_exhaustive();
    logic [6:0] b, want_b;
    logic e, want_e, rb, ra;
    int lat;
    int t, o;
    for (int i = 0; i < 256; i++) begin
      t = i / 16;
      o = i % 16;
      want_e = (t > 9) || (o > 9);
      want_b = want_e ? 7'd0 : 7'(t * 10 + o);
      run_op(8'(i), b, e, lat, rb, ra);
      n_cmp++;
      if (b !== want_b || e !== want_e || lat !== 8) begin
        n_bad++;
        $display("FAIL exhaustive_%02h: got bin=%h err=%b lat=%0d, want %h %b 8",
                 i, b, e, lat, want_b, want_e);
      end
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    bus.in_valid  = 1'b0;
    bus.in_bcd    = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_valid();
    test_invalid();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_conv();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
